// File: rtl/avst_sort_checker.sv
// avst_sort_checker: Avalon-ST sink that captures one packet and checks framing, length and ascending order.
// Ports: clk_i/rst_i (async) / srst_i (sync clear); arm_i starts a packet, latching expected_cnt_i and
// ready_pattern_i; in_* is the Avalon-ST sink; busy_o/done_o/rx_cnt_o report progress; err_* are sticky
// per-packet flags with err_idx_o the first order violation; rd_addr_i/rd_data_o is a 1-cycle readback port.
module avst_sort_checker #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              srst_i,
  input  logic              arm_i,
  input  logic [AWIDTH:0]   expected_cnt_i,
  input  logic [7:0]        ready_pattern_i,
  input  logic [DWIDTH-1:0] in_data_i,
  input  logic              in_valid_i,
  input  logic              in_sop_i,
  input  logic              in_eop_i,
  output logic              in_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [AWIDTH:0]   rx_cnt_o,
  output logic              err_sop_o,
  output logic              err_len_o,
  output logic              err_order_o,
  output logic [AWIDTH:0]   err_idx_o,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  localparam logic [AWIDTH:0] CAP = {1'b1, {AWIDTH{1'b0}}};
  state_t            state;
  logic [7:0]        pat;
  logic [AWIDTH:0]   exp_cnt;
  logic [AWIDTH:0]   nxt_cnt;
  logic              started;
  logic [DWIDTH-1:0] prev;
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic              accept;
  logic              drop;
  logic              counted;
  logic              room;
  logic              arm_ok;
  assign in_ready_o = (state == RECV) && pat[0];
  assign busy_o     = state == RECV;
  assign accept     = in_valid_i && in_ready_o;
  // beats ahead of the first sop are discarded entirely, including any eop they carry
  assign drop       = accept && !started && !in_sop_i;
  assign counted    = accept && !drop;
  assign room       = rx_cnt_o < CAP;
  assign nxt_cnt    = room ? rx_cnt_o + 1'b1 : rx_cnt_o;
  assign arm_ok     = arm_i && (state != RECV);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pat         <= '0;
      exp_cnt     <= '0;
      started     <= 1'b0;
      prev        <= '0;
      done_o      <= 1'b0;
      rx_cnt_o    <= '0;
      err_sop_o   <= 1'b0;
      err_len_o   <= 1'b0;
      err_order_o <= 1'b0;
      err_idx_o   <= '0;
    end else if (srst_i) begin
      state       <= IDLE;
      pat         <= '0;
      exp_cnt     <= '0;
      started     <= 1'b0;
      prev        <= '0;
      done_o      <= 1'b0;
      rx_cnt_o    <= '0;
      err_sop_o   <= 1'b0;
      err_len_o   <= 1'b0;
      err_order_o <= 1'b0;
      err_idx_o   <= '0;
    end else begin
      done_o <= 1'b0;
      if (arm_ok) begin
        state       <= RECV;
        pat         <= (ready_pattern_i == 8'h00) ? 8'hFF : ready_pattern_i;
        exp_cnt     <= expected_cnt_i;
        started     <= 1'b0;
        rx_cnt_o    <= '0;
        err_sop_o   <= 1'b0;
        err_len_o   <= 1'b0;
        err_order_o <= 1'b0;
        err_idx_o   <= '0;
      end else if (state == RECV) begin
        pat <= {pat[0], pat[7:1]};
        if (drop) err_sop_o <= 1'b1;
        if (counted) begin
          started  <= 1'b1;
          prev     <= in_data_i;
          rx_cnt_o <= nxt_cnt;
          if (started && in_sop_i) err_sop_o <= 1'b1;
          if (!room) err_len_o <= 1'b1;
          if (started && (in_data_i < prev)) begin
            err_order_o <= 1'b1;
            if (!err_order_o) err_idx_o <= rx_cnt_o;
          end
          if (in_eop_i) begin
            state  <= DONE;
            done_o <= 1'b1;
            if (nxt_cnt != exp_cnt) err_len_o <= 1'b1;
          end
        end
      end
    end
  end
  // storage carries no reset so it maps onto plain RAM; read-before-write gives old data on collision
  always_ff @(posedge clk_i) begin
    if (counted && room && !srst_i) mem[rx_cnt_o[AWIDTH-1:0]] <= in_data_i;
    rd_data_o <= mem[rd_addr_i];
  end
endmodule
